led_blinker_array: RTL and testbench



---
 rtl/led_blinker_array_pkg.sv | 19 +
 rtl/led_blinker_array_if.sv | 42 ++++
 rtl/led_blinker_array_channel.sv | 113 +++++++++++
 rtl/led_blinker_array.sv | 85 ++++++++
 tb/tb_led_blinker_array.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_blinker_array_pkg.sv
// Shared types and helpers for the LED blinker array.
// Optional PWM dimming is enabled by defining LED_PWM_EN.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'b00,
    LED_ON      = 2'b01,
    LED_BLINK   = 2'b10,
    LED_ONESHOT = 2'b11
  } led_mode_t;

  localparam int unsigned PWM_W = 8;

  // A stored period of zero behaves as one: the phase toggles every clock.
  function automatic logic [31:0] eff_period(input logic [31:0] period);
    return (period == 32'd0) ? 32'd1 : period;
  endfunction

endpackage

// File: rtl/led_blinker_array_if.sv
// Configuration bus of the LED blinker array: write strobe, channel, mode, period, error pulse.
// cfg_duty is present only when LED_PWM_EN is defined.
interface led_blinker_array_if
  import led_pkg::*;
#(
  parameter int unsigned N_CH  = 8,
  parameter int unsigned CNT_W = 26,
  parameter int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
);

  logic             cfg_we;
  logic [CH_W-1:0]  cfg_ch;
  led_mode_t        cfg_mode;
  logic [CNT_W-1:0] cfg_period;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0] cfg_duty;
`endif
  logic             cfg_err;

  modport master (
    output cfg_we,
    output cfg_ch,
    output cfg_mode,
    output cfg_period,
`ifdef LED_PWM_EN
    output cfg_duty,
`endif
    input  cfg_err
  );

  modport slave (
    input  cfg_we,
    input  cfg_ch,
    input  cfg_mode,
    input  cfg_period,
`ifdef LED_PWM_EN
    input  cfg_duty,
`endif
    output cfg_err
  );

endinterface

// File: rtl/led_blinker_array_channel.sv
// One LED channel: period counter, phase, mode, one-shot tracking and registered pre-PWM led.
// With LED_PWM_EN defined the channel also stores its duty value.
module led_channel
  import led_pkg::*;
#(
  parameter int unsigned CNT_W          = 26,
  parameter int unsigned DEFAULT_PERIOD = 50000000,
  parameter led_mode_t   RESET_MODE     = LED_BLINK
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             we,
  input  logic             sync,
  input  led_mode_t        cfg_mode,
  input  logic [CNT_W-1:0] cfg_period,
`ifdef LED_PWM_EN
  input  logic [PWM_W-1:0] cfg_duty,
  output logic [PWM_W-1:0] duty,
`endif
  output logic             led,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  led_mode_t        mode_q, mode_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  logic             busy_q, busy_d;
  logic             led_q, led_d;
  logic [CNT_W-1:0] period_eff;
  logic             wrap;

  assign period_eff = CNT_W'(eff_period(32'(period_q)));
  // >= rather than == keeps cnt bounded even if it ever got ahead of the period.
  assign wrap       = (cnt_q >= period_eff);

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] duty_q, duty_d;
  assign duty = duty_q;
`endif

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    busy_d   = busy_q;
    cnt_d    = wrap ? CntOne : cnt_q + CntOne;
    phase_d  = wrap ? ~phase_q : phase_q;
`ifdef LED_PWM_EN
    duty_d   = duty_q;
`endif

    // A finished one-shot writes itself back to OFF.
    if (mode_q == LED_ONESHOT && busy_q && wrap) begin
      busy_d = 1'b0;
      mode_d = LED_OFF;
    end

    if (sync) begin
      cnt_d   = CntOne;
      phase_d = 1'b0;
    end

    if (we) begin
      mode_d   = cfg_mode;
      period_d = cfg_period;
      cnt_d    = CntOne;
      phase_d  = 1'b0;
      busy_d   = (cfg_mode == LED_ONESHOT);
`ifdef LED_PWM_EN
      duty_d   = cfg_duty;
`endif
    end

    // led follows the next-state values so it changes on the same edge as the state.
    unique case (mode_d)
      LED_OFF:     led_d = 1'b0;
      LED_ON:      led_d = 1'b1;
      LED_BLINK:   led_d = phase_d;
      LED_ONESHOT: led_d = busy_d;
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      mode_q   <= RESET_MODE;
      period_q <= CNT_W'(DEFAULT_PERIOD);
      cnt_q    <= CntOne;
      phase_q  <= 1'b0;
      busy_q   <= 1'b0;
      led_q    <= 1'b0;
`ifdef LED_PWM_EN
      duty_q   <= {PWM_W{1'b1}};
`endif
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      busy_q   <= busy_d;
      led_q    <= led_d;
`ifdef LED_PWM_EN
      duty_q   <= duty_d;
`endif
    end
  end

  assign led  = led_q;
  assign busy = busy_q;

endmodule

// File: rtl/led_blinker_array.sv
// Multi-channel LED pattern generator: channel address decode, invalid-write error, shared PWM.
// Define LED_PWM_EN to add per-channel duty dimming against a free-running 8-bit counter.
module led_blinker_array
  import led_pkg::*;
#(
  parameter int unsigned N_CH           = 8,
  parameter int unsigned CNT_W          = 26,
  parameter int unsigned DEFAULT_PERIOD = 50000000,
  parameter logic [1:0]  RESET_MODE     = 2'b10,
  // Index width; may be widened beyond the minimum so out-of-range indices are expressible.
  parameter int unsigned CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  led_blinker_array_if.slave  cfg,
  input  logic                sync,
  output logic [N_CH-1:0]     led,
  output logic [N_CH-1:0]     busy
);

  logic            ch_valid;
  logic            cfg_err_q, cfg_err_d;
  logic [N_CH-1:0] led_pre;

  assign ch_valid  = (32'(cfg.cfg_ch) < N_CH);
  assign cfg_err_d = cfg.cfg_we && !ch_valid;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
    end
  end

  assign cfg.cfg_err = cfg_err_q;

`ifdef LED_PWM_EN
  logic [PWM_W-1:0] pwm_cnt_q;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic we_ch;
    assign we_ch = cfg.cfg_we && ch_valid && (cfg.cfg_ch == CH_W'(i));

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] duty;
`endif

    led_channel #(
      .CNT_W          (CNT_W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .RESET_MODE     (led_mode_t'(RESET_MODE))
    ) u_channel (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .we         (we_ch),
      .sync       (sync),
      .cfg_mode   (cfg.cfg_mode),
      .cfg_period (cfg.cfg_period),
`ifdef LED_PWM_EN
      .cfg_duty   (cfg.cfg_duty),
      .duty       (duty),
`endif
      .led        (led_pre[i]),
      .busy       (busy[i])
    );

`ifdef LED_PWM_EN
    // Gate of two registers; duty 0 never passes, duty 255 passes 255 of 256 counts.
    assign led[i] = led_pre[i] & (pwm_cnt_q < duty);
`else
    assign led[i] = led_pre[i];
`endif
  end

endmodule

// File: tb/tb_led_blinker_array.sv
// Directed self-checking bench for led_blinker_array (8 channels, 8-bit counters, period 4).
// Define LED_PWM_EN to include the dimming scenario.
module tb_led_blinker_array;
  import led_pkg::*;

  localparam int unsigned N_CH  = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CH_W  = 4;

  logic            sys_clk;
  logic            sys_rst;
  logic            sync;
  logic [N_CH-1:0] led;
  logic [N_CH-1:0] busy;

  int n_vec;
  int n_miss;

  led_blinker_array_if #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W)) cfg_bus ();

  led_blinker_array #(
    .N_CH           (N_CH),
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (4),
    .RESET_MODE     (2'b10),
    .CH_W           (CH_W)
  ) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .cfg     (cfg_bus.slave),
    .sync    (sync),
    .led     (led),
    .busy    (busy)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic step(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic cfg_set(input logic [CH_W-1:0] ch, input led_mode_t mode,
                         input logic [CNT_W-1:0] period);
    cfg_bus.cfg_we     = 1'b1;
    cfg_bus.cfg_ch     = ch;
    cfg_bus.cfg_mode   = mode;
    cfg_bus.cfg_period = period;
  endtask

  task automatic cfg_idle();
    cfg_bus.cfg_we = 1'b0;
  endtask

  // Reset is released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset();
    cfg_idle();
    sync    = 1'b0;
    sys_rst = 1'b1;
    step(2);
    sys_rst = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step(2);
    n_vec++;
    if (led !== 8'h00) begin n_miss++; $display("FAIL reset_led: got %h want 00", led); end
    n_vec++;
    if (busy !== 8'h00) begin n_miss++; $display("FAIL reset_busy: got %h want 00", busy); end
    n_vec++;
    if (cfg_bus.cfg_err !== 1'b0) begin
      n_miss++; $display("FAIL reset_err: got %b want 0", cfg_bus.cfg_err);
    end
    sys_rst = 1'b0;
    step(3);
    n_vec++;
    if (led !== 8'h00) begin n_miss++; $display("FAIL blink_e3: got %h want 00", led); end
    step(1);
    n_vec++;
    if (led !== 8'hFF) begin n_miss++; $display("FAIL blink_e4: got %h want ff", led); end
    step(3);
    n_vec++;
    if (led !== 8'hFF) begin n_miss++; $display("FAIL blink_e7: got %h want ff", led); end
    step(1);
    n_vec++;
    if (led !== 8'h00) begin n_miss++; $display("FAIL blink_e8: got %h want 00", led); end
    n_vec++;
    if (cfg_bus.cfg_err !== 1'b0) begin
      n_miss++; $display("FAIL blink_err: got %b want 0", cfg_bus.cfg_err);
    end
  endtask

  task automatic test_blink_fast();
    do_reset();
    cfg_set(4'd2, LED_BLINK, 8'd1);
    step(1);
    cfg_idle();
    n_vec++;
    if (led[2:1] !== 2'b00) begin n_miss++; $display("FAIL fast_e1: got %b want 00", led[2:1]); end
    for (int k = 2; k <= 9; k++) begin
      step(1);
      n_vec++;
      if (led[2] !== ((k % 2) == 0)) begin
        n_miss++; $display("FAIL fast_ch2 e%0d: got %b want %b", k, led[2], (k % 2) == 0);
      end
      n_vec++;
      if (led[1] !== (k >= 4 && k <= 7)) begin
        n_miss++; $display("FAIL fast_ch1 e%0d: got %b want %b", k, led[1], (k >= 4 && k <= 7));
      end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    cfg_set(4'd3, LED_ONESHOT, 8'd5);
    step(1);
    cfg_idle();
    for (int k = 1; k <= 5; k++) begin
      n_vec++;
      if (busy !== 8'h08 || led[3] !== 1'b1) begin
        n_miss++; $display("FAIL oneshot_on e%0d: busy %h led3 %b want 08 1", k, busy, led[3]);
      end
      step(1);
    end
    n_vec++;
    if (busy !== 8'h00 || led[3] !== 1'b0) begin
      n_miss++; $display("FAIL oneshot_off: busy %h led3 %b want 00 0", busy, led[3]);
    end
    n_vec++;
    if (dut.g_ch[3].u_channel.mode_q !== LED_OFF) begin
      n_miss++; $display("FAIL oneshot_mode: got %0d want 0", dut.g_ch[3].u_channel.mode_q);
    end
    for (int k = 0; k < 10; k++) begin
      step(1);
      n_vec++;
      if (led[3] !== 1'b0) begin n_miss++; $display("FAIL oneshot_stay %0d: got 1 want 0", k); end
    end
  endtask

  task automatic test_sync();
    logic [7:0] exp_led [6];
    exp_led = '{8'h90, 8'h90, 8'h90, 8'h92, 8'hFB, 8'hFF};
    do_reset();
    cfg_set(4'd1, LED_BLINK, 8'd3);
    step(1);
    cfg_set(4'd2, LED_BLINK, 8'd5);
    step(1);
    cfg_set(4'd4, LED_ON, 8'd4);
    step(1);
    cfg_idle();
    step(7);
    sync = 1'b1;
    cfg_set(4'd7, LED_ON, 8'd4);
    step(1);
    sync = 1'b0;
    cfg_idle();
    for (int k = 0; k < 6; k++) begin
      n_vec++;
      if (led !== exp_led[k]) begin
        n_miss++; $display("FAIL sync s+%0d: got %h want %h", k, led, exp_led[k]);
      end
      if (k < 5) step(1);
    end
  endtask

  task automatic test_invalid();
    do_reset();
    step(2);
    cfg_set(4'd9, LED_ON, 8'd1);
    step(1);
    cfg_idle();
    n_vec++;
    if (cfg_bus.cfg_err !== 1'b1 || led !== 8'h00) begin
      n_miss++; $display("FAIL inv9_pulse: err %b led %h want 1 00", cfg_bus.cfg_err, led);
    end
    step(1);
    n_vec++;
    if (cfg_bus.cfg_err !== 1'b0 || led !== 8'hFF) begin
      n_miss++; $display("FAIL inv9_after: err %b led %h want 0 ff", cfg_bus.cfg_err, led);
    end
    cfg_set(4'd8, LED_OFF, 8'd1);
    step(1);
    cfg_idle();
    n_vec++;
    if (cfg_bus.cfg_err !== 1'b1 || led !== 8'hFF) begin
      n_miss++; $display("FAIL inv8_pulse: err %b led %h want 1 ff", cfg_bus.cfg_err, led);
    end
    step(1);
    n_vec++;
    if (cfg_bus.cfg_err !== 1'b0) begin
      n_miss++; $display("FAIL inv8_after: err %b want 0", cfg_bus.cfg_err);
    end
    cfg_set(4'd7, LED_OFF, 8'd4);
    step(1);
    cfg_idle();
    n_vec++;
    if (cfg_bus.cfg_err !== 1'b0 || led !== 8'h7F || busy !== 8'h00) begin
      n_miss++;
      $display("FAIL valid7: err %b led %h busy %h want 0 7f 00", cfg_bus.cfg_err, led, busy);
    end
  endtask

  task automatic test_reset_mid_oneshot();
    do_reset();
    cfg_set(4'd3, LED_ONESHOT, 8'd20);
    step(1);
    cfg_idle();
    step(2);
    n_vec++;
    if (busy[3] !== 1'b1 || led[3] !== 1'b1) begin
      n_miss++; $display("FAIL midrst_pre: busy3 %b led3 %b want 1 1", busy[3], led[3]);
    end
    #2 sys_rst = 1'b1;
    #1;
    n_vec++;
    if (busy !== 8'h00 || led !== 8'h00) begin
      n_miss++; $display("FAIL midrst_async: busy %h led %h want 00 00", busy, led);
    end
    step(1);
    sys_rst = 1'b0;
  endtask

`ifdef LED_PWM_EN
  task automatic test_pwm();
    int ones;
    do_reset();
    cfg_bus.cfg_duty = 8'd64;
    cfg_set(4'd0, LED_ON, 8'd1);
    step(1);
    cfg_idle();
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      if (led[0] === 1'b1) ones++;
      step(1);
    end
    n_vec++;
    if (ones != 64) begin n_miss++; $display("FAIL pwm_64: got %0d want 64", ones); end
    cfg_bus.cfg_duty = 8'd0;
    cfg_set(4'd0, LED_ON, 8'd1);
    step(1);
    cfg_idle();
    ones = 0;
    for (int k = 0; k < 256; k++) begin
      if (led[0] === 1'b1) ones++;
      step(1);
    end
    n_vec++;
    if (ones != 0) begin n_miss++; $display("FAIL pwm_0: got %0d want 0", ones); end
    cfg_bus.cfg_duty = 8'hFF;
  endtask
`endif

  initial begin
    n_vec              = 0;
    n_miss             = 0;
    sys_rst            = 1'b1;
    sync               = 1'b0;
    cfg_bus.cfg_we     = 1'b0;
    cfg_bus.cfg_ch     = '0;
    cfg_bus.cfg_mode   = LED_OFF;
    cfg_bus.cfg_period = '0;
`ifdef LED_PWM_EN
    cfg_bus.cfg_duty   = 8'hFF;
`endif
    test_reset();
    test_blink_fast();
    test_oneshot();
    test_sync();
    test_invalid();
    test_reset_mid_oneshot();
`ifdef LED_PWM_EN
    test_pwm();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
